// File: rtl/perf_ctr_pkg.sv
// Shared register map and address decode helper for the performance counter bank.
package perf_ctr_pkg;

    localparam logic [31:0] OFF_CTRL      = 32'h00;
    localparam logic [31:0] OFF_OVF       = 32'h04;
    localparam logic [31:0] OFF_CLEAR     = 32'h08;
    localparam logic [31:0] OFF_HI_SHADOW = 32'h0C;
    localparam logic [31:0] CNT_BASE      = 32'h10;
    localparam logic [31:0] CNT_STRIDE    = 32'd4;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } cnt_sel_t;

    // Maps a byte address onto a counter channel; idx is meaningless when valid is 0.
    function automatic cnt_sel_t cnt_decode(input logic [31:0] byte_addr, input int unsigned num_cnt);
        cnt_sel_t    sel;
        logic [31:0] off;
        off       = byte_addr & ~32'h3;
        sel.valid = (off >= CNT_BASE) && (off < CNT_BASE + CNT_STRIDE * num_cnt);
        sel.idx   = 4'((off - CNT_BASE) / CNT_STRIDE);
        return sel;
    endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// One event counter: clear beats load beats increment; wrap_pulse flags an increment from all-ones.
module perf_counter_channel #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 wrap_pulse
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d    = count_q;
        wrap_pulse = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d    = count_q + CNT_WIDTH'(1);
            wrap_pulse = &count_q;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of NUM_CNT event counters with enable mask, sticky overflow,
// registered single-cycle-latency readout and a high-word shadow for tear-free wide reads.
module perf_counter_bank
    import perf_ctr_pkg::*;
#(
    parameter int                   NUM_CNT    = 4,
    parameter int                   CNT_WIDTH  = 32,
    parameter int                   ADDR_WIDTH = 8,
    parameter logic [NUM_CNT-1:0]   EN_RESET   = {NUM_CNT{1'b1}}
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  freeze,
    input  logic [NUM_CNT-1:0]    event_in,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic                  overflow_any
);

    logic [NUM_CNT-1:0]   ctrl_q, ctrl_d, ovf_q, ovf_d;
    logic [NUM_CNT-1:0]   inc, clr, load, wrap;
    logic [31:0]          shadow_q, shadow_d, rdata_q, rdata_d, read_val;
    logic                 rdata_valid_q, rdata_valid_d;
    logic [CNT_WIDTH-1:0] count  [NUM_CNT];
    logic [31:0]          cnt_lo [NUM_CNT];
    logic [31:0]          cnt_hi [NUM_CNT];
    logic [31:0]          word_addr;
    cnt_sel_t             sel;
    logic                 sel_ctrl, sel_ovf, sel_clear, sel_hi;

    assign word_addr = 32'(addr) & ~32'h3;
    assign sel       = cnt_decode(word_addr, NUM_CNT);
    assign sel_ctrl  = (word_addr == OFF_CTRL);
    assign sel_ovf   = (word_addr == OFF_OVF);
    assign sel_clear = (word_addr == OFF_CLEAR);
    assign sel_hi    = (word_addr == OFF_HI_SHADOW);

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_ch
        assign inc[g]  = ctrl_q[g] & event_in[g] & ~freeze;
        assign clr[g]  = we & sel_clear & wdata[g];
        assign load[g] = we & sel.valid & (sel.idx == 4'(g));

        perf_counter_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .CLK        (CLK),
            .reset      (reset),
            .inc        (inc[g]),
            .clr        (clr[g]),
            .load       (load[g]),
            .load_val   (CNT_WIDTH'(wdata)),
            .count      (count[g]),
            .wrap_pulse (wrap[g])
        );

        // Upper word is zero for counters of 32 bits or less.
        assign cnt_lo[g] = 32'(count[g]);
        assign cnt_hi[g] = 32'(count[g] >> 32);
    end

    always_comb begin
        ctrl_d        = ctrl_q;
        ovf_d         = ovf_q;
        shadow_d      = shadow_q;
        rdata_d       = rdata_q;
        rdata_valid_d = re;
        read_val      = '0;

        if (we && sel_ctrl) ctrl_d = wdata[NUM_CNT-1:0];
        if (we && sel_ovf)  ovf_d  = ovf_q & ~wdata[NUM_CNT-1:0];
        // A fresh wrap wins over a simultaneous write-1-to-clear.
        ovf_d = ovf_d | wrap;

        if (sel_ctrl) read_val = 32'(ctrl_q);
        if (sel_ovf)  read_val = 32'(ovf_q);
        if (sel_hi)   read_val = shadow_q;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (sel.valid && sel.idx == 4'(i)) read_val = cnt_lo[i];
        end

        if (re) begin
            rdata_d = read_val;
            for (int i = 0; i < NUM_CNT; i++) begin
                if (sel.valid && sel.idx == 4'(i)) shadow_d = cnt_hi[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ctrl_q        <= EN_RESET;
            ovf_q         <= '0;
            shadow_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            ovf_q         <= ovf_d;
            shadow_q      <= shadow_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign rdata        = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign overflow_any = |ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: three banks (32/16/64-bit counters) share clock and reset;
// reads push expected data, a negedge monitor pops and compares on rdata_valid.
module tb_perf_counter_bank;

    typedef struct {
        logic [31:0] val;
        logic [7:0]  adr;
        int          id;
    } exp_t;

    logic        CLK;
    logic        reset;
    logic [7:0]  addr_v   [3];
    logic        we_v     [3];
    logic        re_v     [3];
    logic        freeze_v [3];
    logic [3:0]  ev_v     [3];
    logic [31:0] wd_v     [3];
    logic [31:0] rd_v     [3];
    logic        rv_v     [3];
    logic        ovfa_v   [3];

    exp_t exp_q [3][$];
    int   errors = 0;
    int   checks = 0;
    int   rd_id  = 0;

    perf_counter_bank #(.CNT_WIDTH(32)) u_w32 (
        .CLK(CLK), .reset(reset), .freeze(freeze_v[0]), .event_in(ev_v[0]), .addr(addr_v[0]),
        .we(we_v[0]), .wdata(wd_v[0]), .re(re_v[0]), .rdata(rd_v[0]), .rdata_valid(rv_v[0]),
        .overflow_any(ovfa_v[0]));

    perf_counter_bank #(.CNT_WIDTH(16)) u_w16 (
        .CLK(CLK), .reset(reset), .freeze(freeze_v[1]), .event_in(ev_v[1]), .addr(addr_v[1]),
        .we(we_v[1]), .wdata(wd_v[1]), .re(re_v[1]), .rdata(rd_v[1]), .rdata_valid(rv_v[1]),
        .overflow_any(ovfa_v[1]));

    perf_counter_bank #(.CNT_WIDTH(64)) u_w64 (
        .CLK(CLK), .reset(reset), .freeze(freeze_v[2]), .event_in(ev_v[2]), .addr(addr_v[2]),
        .we(we_v[2]), .wdata(wd_v[2]), .re(re_v[2]), .rdata(rd_v[2]), .rdata_valid(rv_v[2]),
        .overflow_any(ovfa_v[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge CLK) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rv_v[k] === 1'b1) begin
                checks++;
                if (exp_q[k].size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid inst=%0d rdata=%h (no read outstanding)", k, rd_v[k]);
                end else begin
                    e = exp_q[k].pop_front();
                    if (rd_v[k] !== e.val) begin
                        errors++;
                        $display("FAIL read#%0d inst=%0d addr=%h got=%h expected=%h",
                                 e.id, k, e.adr, rd_v[k], e.val);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] a, input logic [31:0] v);
        exp_t e;
        e.val = v;
        e.adr = a;
        e.id  = rd_id++;
        exp_q[k].push_back(e);
    endtask

    task automatic wr(input int k, input logic [7:0] a, input logic [31:0] d);
        addr_v[k] = a; wd_v[k] = d; we_v[k] = 1'b1;
        tick();
        we_v[k] = 1'b0;
    endtask

    task automatic rd(input int k, input logic [7:0] a, input logic [31:0] v);
        addr_v[k] = a; re_v[k] = 1'b1;
        push(k, a, v);
        tick();
        re_v[k] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr_v[k] = '0; we_v[k] = 1'b0; re_v[k] = 1'b0;
            freeze_v[k] = 1'b0; ev_v[k] = '0; wd_v[k] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_rdata_%0d", k), rd_v[k], 32'h0);
            check($sformatf("reset_valid_%0d", k), 32'(rv_v[k]), 32'h0);
            check($sformatf("reset_ovfany_%0d", k), 32'(ovfa_v[k]), 32'h0);
        end
        reset = 1'b0;
        tick();

        // Reset values and single-cycle valid pulse
        rd(0, 8'h00, 32'hF);
        rd(0, 8'h04, 32'h0);
        for (int i = 0; i < 4; i++) rd(0, 8'(8'h10 + 4 * i), 32'h0);
        check("valid_after_read", 32'(rv_v[0]), 32'h1);
        tick();
        check("valid_one_cycle", 32'(rv_v[0]), 32'h0);

        // Counting, freeze, enable mask
        wr(0, 8'h00, 32'hF);
        ev_v[0] = 4'b0101;
        repeat (10) tick();
        ev_v[0] = 4'b0000;
        rd(0, 8'h10, 32'd10); rd(0, 8'h14, 32'd0); rd(0, 8'h18, 32'd10); rd(0, 8'h1C, 32'd0);
        freeze_v[0] = 1'b1; ev_v[0] = 4'b0101;
        repeat (5) tick();
        freeze_v[0] = 1'b0; ev_v[0] = 4'b0000;
        rd(0, 8'h10, 32'd10); rd(0, 8'h18, 32'd10);
        wr(0, 8'h00, 32'h1);
        ev_v[0] = 4'b0101;
        repeat (3) tick();
        ev_v[0] = 4'b0000;
        rd(0, 8'h10, 32'd13); rd(0, 8'h18, 32'd10); rd(0, 8'h00, 32'h1);

        // 16-bit wrap, sticky overflow, set-beats-clear, truncation
        wr(1, 8'h14, 32'h0000_FFFE);
        ev_v[1] = 4'b0010;
        repeat (3) tick();
        ev_v[1] = 4'b0000;
        check("ovf_any_after_wrap", 32'(ovfa_v[1]), 32'h1);
        rd(1, 8'h14, 32'h0001);
        rd(1, 8'h04, 32'h2);
        wr(1, 8'h14, 32'h0000_FFFF);
        addr_v[1] = 8'h04; wd_v[1] = 32'h2; we_v[1] = 1'b1; ev_v[1] = 4'b0010;
        tick();
        we_v[1] = 1'b0; ev_v[1] = 4'b0000;
        rd(1, 8'h04, 32'h2);
        rd(1, 8'h14, 32'h0);
        wr(1, 8'h04, 32'h2);
        rd(1, 8'h04, 32'h0);
        check("ovf_any_after_w1c", 32'(ovfa_v[1]), 32'h0);
        wr(1, 8'h10, 32'h1234_5678);
        rd(1, 8'h10, 32'h5678);
        rd(1, 8'h0C, 32'h0);

        // Read-with-write returns pre-write value; clear/load beat a same-cycle event
        wr(0, 8'h00, 32'hF);
        wr(0, 8'h10, 32'd7);
        addr_v[0] = 8'h10; wd_v[0] = 32'd0; we_v[0] = 1'b1; re_v[0] = 1'b1; ev_v[0] = 4'b0001;
        push(0, 8'h10, 32'd7);
        tick();
        we_v[0] = 1'b0; re_v[0] = 1'b0; ev_v[0] = 4'b0000;
        rd(0, 8'h10, 32'd0);
        ev_v[0] = 4'b0001;
        repeat (3) tick();
        ev_v[0] = 4'b0000;
        rd(0, 8'h10, 32'd3);
        addr_v[0] = 8'h18; wd_v[0] = 32'd100; we_v[0] = 1'b1; ev_v[0] = 4'b0100;
        tick();
        addr_v[0] = 8'h08; wd_v[0] = 32'h1; ev_v[0] = 4'b0001;
        tick();
        we_v[0] = 1'b0; ev_v[0] = 4'b0000;
        rd(0, 8'h10, 32'd0);
        rd(0, 8'h18, 32'd100);
        rd(0, 8'h08, 32'h0);
        rd(0, 8'h0C, 32'h0);

        // 64-bit: shadow captures the same pre-edge value as the low word
        wr(2, 8'h10, 32'hFFFF_FFFF);
        addr_v[2] = 8'h10; re_v[2] = 1'b1; ev_v[2] = 4'b0001;
        push(2, 8'h10, 32'hFFFF_FFFF);
        tick();
        re_v[2] = 1'b0; ev_v[2] = 4'b0000;
        rd(2, 8'h0C, 32'h0);
        rd(2, 8'h10, 32'h0);
        rd(2, 8'h0C, 32'h1);
        rd(2, 8'h04, 32'h0);
        wr(2, 8'h14, 32'h0000_ABCD);
        rd(2, 8'h14, 32'h0000_ABCD);
        rd(2, 8'h0C, 32'h0);

        // Async reset while counting and while a read response is on the bus
        wr(0, 8'h00, 32'h3);
        ev_v[0] = 4'b1111;
        repeat (4) tick();
        addr_v[0] = 8'h10; re_v[0] = 1'b1;
        push(0, 8'h10, 32'd4);
        tick();
        re_v[0] = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        check("reset_drops_valid", 32'(rv_v[0]), 32'h0);
        check("reset_clears_rdata", rd_v[0], 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        ev_v[0] = 4'b0000;
        reset = 1'b0;
        tick();
        rd(0, 8'h00, 32'hF);
        for (int i = 0; i < 4; i++) rd(0, 8'(8'h10 + 4 * i), 32'h0);
        rd(0, 8'h04, 32'h0);
        rd(0, 8'h40, 32'h0);
        rd(2, 8'h0C, 32'h0);
        rd(1, 8'h14, 32'h0);

        repeat (3) tick();
        for (int k = 0; k < 3; k++)
            check($sformatf("outstanding_reads_%0d", k), 32'(exp_q[k].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised bank of memory-mapped event counters. It generalises the pipeline's fixed cycle/instruction counters to NUM_CNT channels with configurable width, per-channel enable, global freeze, preset, sticky overflow and atomic wide readout. It sits beside the datapath on the MMIO decode. Its event inputs come from control (cycle, instruction retire, stall, cache miss, ...), and loads read it through the same RDsel "counter data" path.

Parameters:
NUM_CNT, 4, number of counter channels (1..16)
CNT_WIDTH, 32, counter width in bits (16..64)
ADDR_WIDTH, 8, byte-address width of the MMIO window
EN_RESET, {NUM_CNT{1'b1}}, enable mask loaded at reset

Ports:
CLK  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
freeze  input  1  when 1, no counter increments (e.g. tie to Stall for debug)
event_in  input  NUM_CNT  per-channel increment request, sampled each cycle
addr  input  ADDR_WIDTH  MMIO byte address, [1:0] ignored
we  input  1  write strobe, single cycle
wdata  input  32  write data
re  input  1  read strobe, single cycle
rdata  output  32  registered read data
rdata_valid  output  1  high exactly one cycle after an accepted re
overflow_any  output  1  OR of all sticky overflow bits

Behaviour:
- Reset (async assert): counters=0, enable=EN_RESET, overflow=0, shadow=0, rdata=0, rdata_valid=0, overflow_any=0.
- Register map (word offsets):
  - 0x00 CTRL: [NUM_CNT-1:0] enable mask, R/W.
  - 0x04 OVF: sticky overflow bits. Read returns them; write-1-to-clear.
  - 0x08 CLEAR: write-only. Counters whose wdata bit is 1 are zeroed. Reads return 0.
  - 0x0C HI_SHADOW: read-only upper word latched on the last counter read.
  - 0x10+4*i CNT_i: low 32 bits of counter i, for i < NUM_CNT.
  - All other offsets: writes ignored, reads return 0.
- Increment: counter i += 1 in a cycle when enable[i] & event_in[i] & ~freeze.
- Counter arithmetic is modulo 2^CNT_WIDTH.
- Wrap: increment from all-ones gives 0 and sets OVF[i] in the same edge.
- Counter writes: writing CNT_i loads wdata zero-extended, or truncated when CNT_WIDTH < 32. Upper bits become 0.
- Priority per counter per cycle: CLEAR write > CNT_i load > increment.
  - A counter cleared or loaded in a cycle with an event does not count that event.
  - Clear or load does not alter OVF.
- OVF priority: a new overflow set beats a simultaneous W1C of the same bit, so the bit remains 1.
- Read handling, latency 1:
  - On re, rdata is registered the next edge and rdata_valid pulses for that cycle.
  - The value returned is the pre-edge value; an increment in the same cycle is not visible.
  - re and we in the same cycle: both are performed, and the read returns the pre-write value.
- Atomic wide read:
  - When CNT_WIDTH > 32, a read of CNT_i latches bits [CNT_WIDTH-1:32] of that same pre-edge value into HI_SHADOW, zero-extended.
  - Software reads low word then HI_SHADOW, which gives a tear-free 64-bit value.
  - When CNT_WIDTH <= 32, HI_SHADOW always reads 0.
- overflow_any is combinational OR of the OVF register, so it updates the cycle after the overflowing edge.
- Reset mid-operation: all state returns to reset values immediately. A pending rdata_valid is dropped.
- freeze does not block MMIO reads, writes, clears or loads.

Decomposition:
- Package perf_ctr_pkg holds:
  - register offset constants (CTRL, OVF, CLEAR, HI_SHADOW, CNT_BASE);
  - the CNT_STRIDE of 4;
  - a function mapping a byte address to a channel index plus a valid flag.
- Sub-module perf_counter_channel: one counter with inputs inc, clr, load, load_val and outputs count, wrap_pulse.
  - It is instantiated NUM_CNT times with a generate loop.
  - The top level holds decode, CTRL, OVF, shadow and the read mux.

Test Plan:
- Reset -> read 0x00 returns 0xF (NUM_CNT=4), 0x04 returns 0, CNT_0..3 return 0; rdata_valid only on the cycle after re.
- Enable all and drive event_in=4'b0101 for 10 cycles with freeze=0 -> CNT_0=10, CNT_1=0, CNT_2=10, CNT_3=0. Repeat with freeze=1 for 5 cycles -> values unchanged.
- CNT_WIDTH=16: write CNT_1=0xFFFE, pulse event_in[1] 3 times -> CNT_1=0x0001, OVF=0x2, overflow_any=1. Write 0x2 to OVF in the same cycle as a new wrap -> OVF stays 0x2. W1C alone -> 0.
- Same-cycle CLEAR=0x1, CNT_0 event, and read of CNT_0 (value 7) -> rdata=7, next read 0. Load CNT_2=100 with event_in[2]=1 -> 100, not 101.
- CNT_WIDTH=64: load counter 0 upper bits via repeated wrap of low word, or force to 0x1_FFFF_FFFF. Read CNT_0 while event active -> low=0xFFFFFFFF, then HI_SHADOW=0x1 even though counter has since rolled to 0x2_0000_0000.
- Assert reset asynchronously mid-count and during a pending read -> all counters 0, enable=EN_RESET, rdata_valid deasserted with no pulse; read of unmapped 0x40 -> 0.
